// File: rtl/alu_issue_stage_if.sv
// ALU operation encoding plus the bundle of fetch, regfile, write-back and EX
// signals that connects the issue stage to its neighbours.
package mypkg;
  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND
  } alu_op_e;
endpackage

interface alu_issue_stage_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
);
  logic                 instr_valid_i;
  logic                 instr_ready_o;
  logic [31:0]          instr_i;
  logic [XLEN-1:0]      pc_i;
  logic [RF_AW-1:0]     rs1_addr_o;
  logic [RF_AW-1:0]     rs2_addr_o;
  logic [XLEN-1:0]      rs1_data_i;
  logic [XLEN-1:0]      rs2_data_i;
  logic                 wb_valid_i;
  logic [RF_AW-1:0]     wb_rd_i;
  logic [XLEN-1:0]      wb_data_i;
  logic                 ex_valid_o;
  logic                 ex_ready_i;
  logic [XLEN-1:0]      operand_a_o;
  logic [XLEN-1:0]      operand_b_o;
  mypkg::alu_op_e       alu_op_o;
  logic [RF_AW-1:0]     rd_addr_o;
  logic                 illegal_o;

  // The issue stage itself
  modport slave (
    input  instr_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
           wb_valid_i, wb_rd_i, wb_data_i, ex_ready_i,
    output instr_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o,
           operand_a_o, operand_b_o, alu_op_o, rd_addr_o, illegal_o
  );

  // Surroundings: fetch, register file, write-back and EX
  modport master (
    output instr_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
           wb_valid_i, wb_rd_i, wb_data_i, ex_ready_i,
    input  instr_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o,
           operand_a_o, operand_b_o, alu_op_o, rd_addr_o, illegal_o
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes ALU instructions, reads and bypasses operands,
// and hands a registered bundle to EX through an output register plus skid register.
module alu_issue_stage
  import mypkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  alu_issue_stage_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} buf_state_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  function automatic logic signed [XLEN-1:0] resolve(
    input logic [RF_AW-1:0] addr,
    input logic [XLEN-1:0]  rf_data,
    input logic             wb_vld,
    input logic [RF_AW-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_data
  );
    if (addr == '0)                   return '0;
    else if (wb_vld && wb_rd == addr) return wb_data;
    else                              return rf_data;
  endfunction

  function automatic logic signed [XLEN-1:0] sext12(input logic signed [11:0] imm);
    return XLEN'(imm);
  endfunction

  function automatic alu_op_e op_for(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? A_SUB : A_ADD;
      3'b001:  return A_SLL;
      3'b010:  return A_SLT;
      3'b011:  return A_SLTU;
      3'b100:  return A_XOR;
      3'b101:  return alt ? A_SRA : A_SRL;
      3'b110:  return A_OR;
      default: return A_AND;
    endcase
  endfunction

  buf_state_e state, state_nxt;
  logic       ready_q, vld_p1, illegal_p1;
  logic       load_out, load_skid, move_skid;

  logic [31:0]             instr_p0;
  logic [6:0]              opcode_p0, f7_p0;
  logic [2:0]              f3_p0;
  logic [RF_AW-1:0]        rs1_addr_p0, rs2_addr_p0, rd_p0;
  logic signed [XLEN-1:0]  rs1_val_p0, rs2_val_p0, imm_i_p0, imm_u_p0;
  logic signed [XLEN-1:0]  dec_a_p0, dec_b_p0;
  alu_op_e                 dec_op_p0;
  logic                    dec_legal_p0, accept_p0, take_p0, bad_p0;

  logic signed [XLEN-1:0]  out_a_p1, out_b_p1, skid_a_p1, skid_b_p1;
  alu_op_e                 out_op_p1, skid_op_p1;
  logic [RF_AW-1:0]        out_rd_p1, skid_rd_p1;

  // ---- stage p0: decode, register read and bypass in the accept cycle ----
  assign instr_p0    = bus.instr_i;
  assign opcode_p0   = instr_p0[6:0];
  assign rd_p0       = instr_p0[11:7];
  assign f3_p0       = instr_p0[14:12];
  assign rs1_addr_p0 = instr_p0[19:15];
  assign rs2_addr_p0 = instr_p0[24:20];
  assign f7_p0       = instr_p0[31:25];

  assign rs1_val_p0 = resolve(rs1_addr_p0, bus.rs1_data_i, bus.wb_valid_i, bus.wb_rd_i, bus.wb_data_i);
  assign rs2_val_p0 = resolve(rs2_addr_p0, bus.rs2_data_i, bus.wb_valid_i, bus.wb_rd_i, bus.wb_data_i);
  assign imm_i_p0   = sext12(instr_p0[31:20]);
  assign imm_u_p0   = XLEN'(signed'({instr_p0[31:12], 12'b0}));

  always_comb begin
    dec_legal_p0 = 1'b0;
    dec_op_p0    = A_ADD;
    dec_a_p0     = rs1_val_p0;
    dec_b_p0     = rs2_val_p0;
    case (opcode_p0)
      OPC_OP: begin
        dec_op_p0    = op_for(f3_p0, f7_p0 == F7_ALT);
        dec_legal_p0 = (f7_p0 == F7_BASE) ||
                       (f7_p0 == F7_ALT && (f3_p0 == 3'b000 || f3_p0 == 3'b101));
      end
      OPC_IMM: begin
        dec_b_p0 = imm_i_p0;
        if (f3_p0 == 3'b001 || f3_p0 == 3'b101) begin
          // shift-immediates reuse f7 as a funct field, shamt is zero-extended
          dec_b_p0     = XLEN'(instr_p0[24:20]);
          dec_op_p0    = op_for(f3_p0, f7_p0 == F7_ALT);
          dec_legal_p0 = (f7_p0 == F7_BASE) || (f7_p0 == F7_ALT && f3_p0 == 3'b101);
        end else begin
          dec_op_p0    = op_for(f3_p0, 1'b0);
          dec_legal_p0 = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_a_p0     = '0;
        dec_b_p0     = imm_u_p0;
        dec_legal_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a_p0     = bus.pc_i;
        dec_b_p0     = imm_u_p0;
        dec_legal_p0 = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept_p0 = bus.instr_valid_i && ready_q;
  assign take_p0   = accept_p0 && dec_legal_p0;
  assign bad_p0    = accept_p0 && !dec_legal_p0;

  // Illegal instructions are consumed but leave the buffer untouched
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: if (take_p0) begin
        load_out  = 1'b1;
        state_nxt = FULL;
      end
      FULL: begin
        if (take_p0 && bus.ex_ready_i) begin
          load_out = 1'b1;
        end else if (take_p0) begin
          load_skid = 1'b1;
          state_nxt = SKID;
        end else if (bus.ex_ready_i) begin
          state_nxt = EMPTY;
        end
      end
      SKID: if (bus.ex_ready_i) begin
        move_skid = 1'b1;
        state_nxt = FULL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage p1: output register and skid register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= EMPTY;
      ready_q    <= 1'b1;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      out_a_p1   <= '0;
      out_b_p1   <= '0;
      out_op_p1  <= A_ADD;
      out_rd_p1  <= '0;
    end else begin
      state      <= state_nxt;
      ready_q    <= (state_nxt != SKID);
      vld_p1     <= (state_nxt != EMPTY);
      illegal_p1 <= bad_p0;
      if (load_out) begin
        out_a_p1  <= dec_a_p0;
        out_b_p1  <= dec_b_p0;
        out_op_p1 <= dec_op_p0;
        out_rd_p1 <= rd_p0;
      end else if (move_skid) begin
        out_a_p1  <= skid_a_p1;
        out_b_p1  <= skid_b_p1;
        out_op_p1 <= skid_op_p1;
        out_rd_p1 <= skid_rd_p1;
      end
    end
  end

  // Skid contents are only meaningful in SKID, so they carry no reset
  always_ff @(posedge clk_i) begin
    if (load_skid) begin
      skid_a_p1  <= dec_a_p0;
      skid_b_p1  <= dec_b_p0;
      skid_op_p1 <= dec_op_p0;
      skid_rd_p1 <= rd_p0;
    end
  end

  assign bus.instr_ready_o = ready_q;
  assign bus.rs1_addr_o    = rs1_addr_p0;
  assign bus.rs2_addr_o    = rs2_addr_p0;
  assign bus.ex_valid_o    = vld_p1;
  assign bus.operand_a_o   = out_a_p1;
  assign bus.operand_b_o   = out_b_p1;
  assign bus.alu_op_o      = out_op_p1;
  assign bus.rd_addr_o     = out_rd_p1;
  assign bus.illegal_o     = illegal_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;
  import mypkg::*;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h402083B3; // sub  x7,x1,x2
  localparam logic [31:0] I_ADDI  = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_SRAI  = 32'h40335293; // srai x5,x6,3
  localparam logic [31:0] I_SRAIB = 32'h02335293; // srai with f7=0000001
  localparam logic [31:0] I_BADOP = 32'h0000007F;
  localparam logic [31:0] I_XOR   = 32'h0010C133; // xor  x2,x1,x1
  localparam logic [31:0] I_LUI   = 32'hABCDE4B7; // lui  x9,0xABCDE
  localparam logic [31:0] I_AUIPC = 32'h00001217; // auipc x4,0x1

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(XLEN), .RF_AW(RF_AW)) bus ();

  alu_issue_stage #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.instr_valid_i = 1'b0;
    bus.instr_i       = '0;
    bus.pc_i          = '0;
    bus.rs1_data_i    = '0;
    bus.rs2_data_i    = '0;
    bus.wb_valid_i    = 1'b0;
    bus.wb_rd_i       = '0;
    bus.wb_data_i     = '0;
    bus.ex_ready_i    = 1'b1;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", bus.ex_valid_o); end
    n_cmp++; if (bus.instr_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.instr_ready_o); end
    n_cmp++; if (bus.illegal_o !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b want 0", bus.illegal_o); end
    n_cmp++; if (bus.operand_a_o !== 32'h0) begin n_err++; $display("FAIL rst_a: got %h want 0", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'h0) begin n_err++; $display("FAIL rst_b: got %h want 0", bus.operand_b_o); end
    n_cmp++; if (bus.alu_op_o !== A_ADD) begin n_err++; $display("FAIL rst_op: got %0d want %0d", bus.alu_op_o, A_ADD); end
    n_cmp++; if (bus.rd_addr_o !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0d want 0", bus.rd_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_ADD;
    bus.rs1_data_i    = 32'd5;
    bus.rs2_data_i    = 32'd7;
    #1;
    n_cmp++; if (bus.rs1_addr_o !== 5'd1) begin n_err++; $display("FAIL add_rs1addr: got %0d want 1", bus.rs1_addr_o); end
    n_cmp++; if (bus.rs2_addr_o !== 5'd2) begin n_err++; $display("FAIL add_rs2addr: got %0d want 2", bus.rs2_addr_o); end
    tick();
    bus.instr_valid_i = 1'b0;
    n_cmp++; if (bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL add_vld: got %b want 1", bus.ex_valid_o); end
    n_cmp++; if (bus.operand_a_o !== 32'd5) begin n_err++; $display("FAIL add_a: got %h want 5", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'd7) begin n_err++; $display("FAIL add_b: got %h want 7", bus.operand_b_o); end
    n_cmp++; if (bus.alu_op_o !== A_ADD) begin n_err++; $display("FAIL add_op: got %0d want %0d", bus.alu_op_o, A_ADD); end
    n_cmp++; if (bus.rd_addr_o !== 5'd3) begin n_err++; $display("FAIL add_rd: got %0d want 3", bus.rd_addr_o); end
    tick();
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", bus.ex_valid_o); end
  endtask

  task automatic test_addi;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_ADDI;
    bus.rs1_data_i    = 32'h1234;
    tick();
    bus.instr_valid_i = 1'b0;
    n_cmp++; if (bus.operand_a_o !== 32'h0) begin n_err++; $display("FAIL addi_a: got %h want 0", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_b: got %h want ffffffff", bus.operand_b_o); end
    n_cmp++; if (bus.alu_op_o !== A_ADD) begin n_err++; $display("FAIL addi_op: got %0d want %0d", bus.alu_op_o, A_ADD); end
    n_cmp++; if (bus.rd_addr_o !== 5'd1) begin n_err++; $display("FAIL addi_rd: got %0d want 1", bus.rd_addr_o); end
    tick();
  endtask

  task automatic test_shift_illegal;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_SRAI;
    bus.rs1_data_i    = 32'h80;
    tick();
    bus.instr_valid_i = 1'b0;
    n_cmp++; if (bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL srai_vld: got %b want 1", bus.ex_valid_o); end
    n_cmp++; if (bus.operand_a_o !== 32'h80) begin n_err++; $display("FAIL srai_a: got %h want 80", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'd3) begin n_err++; $display("FAIL srai_b: got %h want 3", bus.operand_b_o); end
    n_cmp++; if (bus.alu_op_o !== A_SRA) begin n_err++; $display("FAIL srai_op: got %0d want %0d", bus.alu_op_o, A_SRA); end
    n_cmp++; if (bus.illegal_o !== 1'b0) begin n_err++; $display("FAIL srai_illegal: got %b want 0", bus.illegal_o); end
    tick();
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_SRAIB;
    tick();
    bus.instr_valid_i = 1'b0;
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL badf7_vld: got %b want 0", bus.ex_valid_o); end
    n_cmp++; if (bus.illegal_o !== 1'b1) begin n_err++; $display("FAIL badf7_pulse: got %b want 1", bus.illegal_o); end
    tick();
    n_cmp++; if (bus.illegal_o !== 1'b0) begin n_err++; $display("FAIL badf7_once: got %b want 0", bus.illegal_o); end
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL badf7_novld: got %b want 0", bus.ex_valid_o); end
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_BADOP;
    tick();
    bus.instr_valid_i = 1'b0;
    n_cmp++; if (bus.illegal_o !== 1'b1) begin n_err++; $display("FAIL badop_pulse: got %b want 1", bus.illegal_o); end
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL badop_vld: got %b want 0", bus.ex_valid_o); end
    tick();
  endtask

  task automatic test_bypass;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_XOR;
    bus.rs1_data_i    = 32'h0;
    bus.rs2_data_i    = 32'h0;
    bus.wb_valid_i    = 1'b1;
    bus.wb_rd_i       = 5'd1;
    bus.wb_data_i     = 32'hCAFE;
    tick();
    bus.instr_valid_i = 1'b0;
    bus.wb_valid_i    = 1'b0;
    n_cmp++; if (bus.operand_a_o !== 32'hCAFE) begin n_err++; $display("FAIL byp_a: got %h want cafe", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'hCAFE) begin n_err++; $display("FAIL byp_b: got %h want cafe", bus.operand_b_o); end
    n_cmp++; if (bus.alu_op_o !== A_XOR) begin n_err++; $display("FAIL byp_op: got %0d want %0d", bus.alu_op_o, A_XOR); end
    n_cmp++; if (bus.rd_addr_o !== 5'd2) begin n_err++; $display("FAIL byp_rd: got %0d want 2", bus.rd_addr_o); end
    tick();
  endtask

  task automatic test_back_to_back;
    bus.ex_ready_i    = 1'b0;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_ADD;
    bus.rs1_data_i    = 32'h11;
    bus.rs2_data_i    = 32'h22;
    tick();
    n_cmp++; if (bus.instr_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", bus.instr_ready_o); end
    bus.instr_i       = I_SUB;
    bus.rs1_data_i    = 32'h33;
    bus.rs2_data_i    = 32'h44;
    tick();
    bus.instr_i       = I_LUI;
    bus.rs1_data_i    = 32'h55;
    bus.rs2_data_i    = 32'h66;
    n_cmp++; if (bus.instr_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready0: got %b want 0", bus.instr_ready_o); end
    n_cmp++; if (bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_vld: got %b want 1", bus.ex_valid_o); end
    n_cmp++; if (bus.operand_a_o !== 32'h11) begin n_err++; $display("FAIL b2b_hold_a: got %h want 11", bus.operand_a_o); end
    tick();
    n_cmp++; if (bus.operand_a_o !== 32'h11) begin n_err++; $display("FAIL b2b_stable_a: got %h want 11", bus.operand_a_o); end
    n_cmp++; if (bus.alu_op_o !== A_ADD) begin n_err++; $display("FAIL b2b_stable_op: got %0d want %0d", bus.alu_op_o, A_ADD); end
    n_cmp++; if (bus.instr_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_still0: got %b want 0", bus.instr_ready_o); end
    bus.ex_ready_i = 1'b1;
    tick();
    n_cmp++; if (bus.operand_a_o !== 32'h33) begin n_err++; $display("FAIL b2b_2nd_a: got %h want 33", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'h44) begin n_err++; $display("FAIL b2b_2nd_b: got %h want 44", bus.operand_b_o); end
    n_cmp++; if (bus.alu_op_o !== A_SUB) begin n_err++; $display("FAIL b2b_2nd_op: got %0d want %0d", bus.alu_op_o, A_SUB); end
    n_cmp++; if (bus.rd_addr_o !== 5'd7) begin n_err++; $display("FAIL b2b_2nd_rd: got %0d want 7", bus.rd_addr_o); end
    n_cmp++; if (bus.instr_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %b want 1", bus.instr_ready_o); end
    tick();
    bus.instr_valid_i = 1'b0;
    n_cmp++; if (bus.operand_a_o !== 32'h0) begin n_err++; $display("FAIL b2b_3rd_a: got %h want 0", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'hABCDE000) begin n_err++; $display("FAIL b2b_3rd_b: got %h want abcde000", bus.operand_b_o); end
    n_cmp++; if (bus.rd_addr_o !== 5'd9) begin n_err++; $display("FAIL b2b_3rd_rd: got %0d want 9", bus.rd_addr_o); end
    tick();
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_nodup: got %b want 0", bus.ex_valid_o); end
  endtask

  task automatic test_auipc_reset;
    bus.ex_ready_i    = 1'b1;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = I_AUIPC;
    bus.pc_i          = 32'h100;
    tick();
    n_cmp++; if (bus.operand_a_o !== 32'h100) begin n_err++; $display("FAIL auipc_a: got %h want 100", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'h1000) begin n_err++; $display("FAIL auipc_b: got %h want 1000", bus.operand_b_o); end
    n_cmp++; if (bus.alu_op_o !== A_ADD) begin n_err++; $display("FAIL auipc_op: got %0d want %0d", bus.alu_op_o, A_ADD); end
    n_cmp++; if (bus.rd_addr_o !== 5'd4) begin n_err++; $display("FAIL auipc_rd: got %0d want 4", bus.rd_addr_o); end
    bus.ex_ready_i = 1'b0;
    bus.instr_i    = I_ADD;
    bus.rs1_data_i = 32'h1;
    bus.rs2_data_i = 32'h2;
    tick();
    bus.instr_valid_i = 1'b0;
    n_cmp++; if (bus.instr_ready_o !== 1'b0) begin n_err++; $display("FAIL skid_ready: got %b want 0", bus.instr_ready_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_vld: got %b want 0", bus.ex_valid_o); end
    n_cmp++; if (bus.operand_a_o !== 32'h0) begin n_err++; $display("FAIL arst_a: got %h want 0", bus.operand_a_o); end
    n_cmp++; if (bus.operand_b_o !== 32'h0) begin n_err++; $display("FAIL arst_b: got %h want 0", bus.operand_b_o); end
    n_cmp++; if (bus.rd_addr_o !== 5'd0) begin n_err++; $display("FAIL arst_rd: got %0d want 0", bus.rd_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.ex_ready_i = 1'b1;
    tick();
    n_cmp++; if (bus.instr_ready_o !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", bus.instr_ready_o); end
    n_cmp++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_empty: got %b want 0", bus.ex_valid_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_shift_illegal();
    test_bypass();
    test_back_to_back();
    test_auipc_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage feeding the ALU: it produces the operands and operation that the ALU consumes.
- Accepts one RV32I instruction per cycle from fetch (valid/ready), reads the register file, and applies write-back bypass.
- Emits a registered operand_a/operand_b/alu_op bundle to the ALU via valid/ready.
- A 2-entry buffer (output register plus skid register) makes instr_ready_o a pure flop output.

Parameters:
XLEN, 32, datapath width of operands and pc
RF_AW, 5, register-file address width

Ports:
clk_i  in  1  clock, all flops on rising edge
rst_ni  in  1  reset, asynchronous, active-low
instr_valid_i  in  1  fetch has an instruction
instr_ready_o  out  1  stage can accept (registered)
instr_i  in  32  instruction word
pc_i  in  XLEN  pc of instr_i
rs1_addr_o  out  RF_AW  instr_i[19:15], combinational
rs2_addr_o  out  RF_AW  instr_i[24:20], combinational
rs1_data_i  in  XLEN  regfile read data, same cycle
rs2_data_i  in  XLEN  regfile read data, same cycle
wb_valid_i  in  1  write-back this cycle
wb_rd_i  in  RF_AW  write-back destination
wb_data_i  in  XLEN  write-back data
ex_valid_o  out  1  operand bundle valid
ex_ready_i  in  1  ALU/EX accepts bundle
operand_a_o  out  XLEN  ALU operand A
operand_b_o  out  XLEN  ALU operand B
alu_op_o  out  alu_op_e  ALU operation (mypkg)
rd_addr_o  out  RF_AW  destination register
illegal_o  out  1  one-cycle pulse: unsupported instruction dropped

Behaviour:
- Reset (async on rst_ni low): ex_valid_o=0, instr_ready_o=1, illegal_o=0, operand_a_o=0, operand_b_o=0, alu_op_o=A_ADD, rd_addr_o=0, skid empty. Asserting reset mid-transfer discards both entries.
- Accept condition: instr_valid_i && instr_ready_o. Decode, register read and bypass all resolve in the accept cycle; resolved values are captured.
- Operand resolve for rsN:
  - If addr==0, value is 0.
  - Else if wb_valid_i && wb_rd_i==addr, value is wb_data_i.
  - Else value is rsN_data_i.
- Decode rules:
  - OP (0110011), a=rs1, b=rs2:
    - f3 000 gives ADD (f7 0000000) or SUB (f7 0100000).
    - f3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; each requires f7 0000000.
    - f3 101 gives SRL (f7 0000000) or SRA (f7 0100000).
  - OP-IMM (0010011), a=rs1, b=sign-extended instr[31:20]:
    - ADDI/SLTI/SLTIU/XORI/ORI/ANDI map like OP.
    - SLLI/SRLI/SRAI set b={27'b0, instr[24:20]} and check f7 as for OP.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD.
  - AUIPC (0010111): a=pc_i, b={instr[31:12],12'b0}, ADD.
  - Any other opcode, or a bad f7: the instruction is consumed and not issued. illegal_o=1 in the next cycle only; no buffer state changes.
- rd_addr_o is instr[11:7]. rd==0 is still issued.
- Buffer states:
  - EMPTY: ex_valid_o=0, ready=1. A legal accept moves to FULL.
  - FULL: output register valid, ready=1.
    - Accept with ex_ready_i=1: output register reloads, stay FULL.
    - Accept with ex_ready_i=0: entry goes to skid, move to SKID.
    - ex_ready_i=1 with no accept: move to EMPTY.
  - SKID: ready=0, no accept possible.
    - ex_ready_i=1: skid entry moves into the output register, go to FULL.
- Ordering: strictly in order; the skid entry is always younger than the output entry.
- Output-register contents are stable while ex_valid_o && !ex_ready_i.
- Hazards: no RAW tracking against in-flight entries; upstream guarantees spacing. Bypass applies only at acceptance.
- Throughput: 1 instruction/cycle while ex_ready_i=1. Latency from accept to ex_valid_o is 1 cycle.

Test Plan:
- Reset, then ADD x3,x1,x2 with rs1_data=5, rs2_data=7: next cycle ex_valid_o=1, a=5, b=7, alu_op=A_ADD, rd=3.
- ADDI x1,x0,-1 (0xFFF00093) with rs1_data_i=0x1234: a=0 (x0 forced), b=0xFFFFFFFF, A_ADD.
- SRAI x5,x6,3 (f7=0100000): b=3, A_SRA. Same word with f7=0000001: no ex_valid_o, illegal_o pulses exactly one cycle.
- wb_valid_i=1, wb_rd_i=1, wb_data_i=0xCAFE during accept of XOR x2,x1,x1 (rs1_data_i=0): a=b=0xCAFE.
- Hold ex_ready_i=0 and present 3 back-to-back instructions:
  - Expect 2 accepted, then instr_ready_o=0, operand_a_o stable.
  - Release ex_ready_i: bundles emerge in order, no loss or duplication.
- AUIPC x4,0x1 with pc_i=0x100: a=0x100, b=0x1000, A_ADD. Pulse rst_ni low while in SKID: outputs return to reset values immediately, and instr_ready_o=1 after release.
